// File: rtl/aes_pipe_scheduler_if.sv
// Requester-side bus of the AES pipe scheduler: key load handshake, block
// requests and the shared response channel.
interface aes_pipe_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic                     key_valid;
    logic [127:0]             key_in;
    logic                     key_ready;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*128-1:0]   req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [127:0]             rsp_data;

    modport master (
        output key_valid, key_in, req_valid, req_data,
        input  key_ready, req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  key_valid, key_in, req_valid, req_data,
        output key_ready, req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// Shares one pipelined AES encrypt engine between NUM_REQ requesters: round-robin
// block issue, tag pipe to route results back, and drain/halt/set_key rekeying.
module aes_pipe_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_pipe_scheduler_if.slave bus,
    output logic                eng_set_key,
    output logic [127:0]        eng_key,
    output logic                eng_start,
    output logic [127:0]        eng_state,
    output logic                eng_halt,
    input  logic [127:0]        eng_out,
    input  logic                eng_out_valid,
    output logic                busy,
    output logic                err
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        S_NOKEY,
        S_KEYLOAD,
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
    } tag_t;

    state_t             state, state_nxt;
    logic [TAG_W-1:0]   ptr;
    logic [TAG_W-1:0]   cand;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_any;
    logic [127:0]       grant_data;
    logic [TAG_W-1:0]   issue_tag;
    tag_t               tag_pipe [LATENCY];
    tag_t               head;
    logic [CNT_W-1:0]   in_flight;
    logic               retire;

    assign head   = tag_pipe[LATENCY-1];
    assign retire = eng_out_valid && (in_flight != '0);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.key_ready = 1'b0;
        eng_set_key   = 1'b0;
        eng_halt      = 1'b0;
        unique case (state)
            S_NOKEY:   if (bus.key_valid) state_nxt = S_KEYLOAD;
            S_KEYLOAD: begin
                bus.key_ready = 1'b1;
                eng_set_key   = 1'b1;
                state_nxt     = S_RUN;
            end
            S_RUN:     if (bus.key_valid) state_nxt = S_DRAIN;
            // A block granted in the last RUN cycle is still in eng_start, not yet counted.
            S_DRAIN:   if (in_flight == '0 && !eng_start) state_nxt = S_HALT;
            S_HALT: begin
                eng_halt  = 1'b1;
                state_nxt = S_KEYLOAD;
            end
            default:   state_nxt = S_NOKEY;
        endcase
    end

    // Round-robin search starting at ptr; the first requesting index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr;
        cand      = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = TAG_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (state != S_RUN) grant_any = 1'b0;
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == TAG_W'(i)) grant_data = bus.req_data[i*128 +: 128];
        end
    end

    assign bus.req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    assign busy = (in_flight != '0) || !(state == S_RUN || state == S_NOKEY);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_NOKEY;
            ptr       <= '0;
            eng_start <= 1'b0;
            eng_state <= '0;
            eng_key   <= '0;
            issue_tag <= '0;
        end else begin
            state     <= state_nxt;
            eng_start <= grant_any;
            if (state_nxt == S_KEYLOAD) eng_key <= bus.key_in;
            if (grant_any) begin
                eng_state <= grant_data;
                issue_tag <= grant_idx;
                ptr       <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // NOTE: the tag pipe is reset even though it is a shift register; stale
    // valid bits after reset would otherwise flag errors or route phantom results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{v: eng_start, tag: issue_tag};
            for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            unique case ({eng_start, retire})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            err           <= 1'b0;
        end else begin
            if (eng_out_valid && head.v) begin
                bus.rsp_valid <= NUM_REQ'(1) << head.tag;
                bus.rsp_data  <= eng_out;
            end else begin
                bus.rsp_valid <= '0;
            end
            if (eng_out_valid != head.v) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Bench for aes_pipe_scheduler: AES-128 engine model with the same latency,
// round-robin grant model and a response scoreboard keyed on due cycle.
module tb_aes_pipe_scheduler;
    localparam int NR  = 4;
    localparam int LAT = 11;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         eng_set_key, eng_start, eng_halt, eng_out_valid, busy, err;
    logic [127:0] eng_key, eng_state, eng_out;

    aes_pipe_scheduler_if #(.NUM_REQ(NR)) bus ();

    aes_pipe_scheduler #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .eng_set_key  (eng_set_key),
        .eng_key      (eng_key),
        .eng_start    (eng_start),
        .eng_state    (eng_state),
        .eng_halt     (eng_halt),
        .eng_out      (eng_out),
        .eng_out_valid(eng_out_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]) ^ rc, sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int b = 0; b < 16; b++) t[b] = sbox(s[b]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    // ---------------- engine model: LAT-stage pipe, shares rst_n ----------------
    logic [LAT-1:0] ev;
    logic [127:0]   ed [LAT];
    logic [127:0]   ekey;
    logic           force_ov = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev   <= '0;
            ekey <= '0;
        end else begin
            if (eng_set_key) ekey <= eng_key;
            ev    <= {ev[LAT-2:0], eng_start};
            ed[0] <= eng_start ? aes128(ekey, eng_state) : 128'h0;
            for (int i = 1; i < LAT; i++) ed[i] <= ed[i-1];
        end
    end
    assign eng_out       = ed[LAT-1];
    assign eng_out_valid = ev[LAT-1] | force_ov;

    // ---------------- grant model and scoreboard ----------------
    typedef struct {
        int           owner;
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t         sb [$];
    logic         model_run = 1'b0;
    int           mptr = 0;
    int           mon_g;
    logic [127:0] mkey = '0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            mon_g = model_run ? rr_pick(bus.req_valid, mptr) : -1;
            check("req_ready", 128'(bus.req_ready), (mon_g >= 0) ? (128'(1) << mon_g) : 128'h0);
            if (mon_g >= 0) begin
                sb.push_back('{owner: mon_g, data: aes128(mkey, bus.req_data[128*mon_g +: 128]),
                               due: cyc + LAT + 2});
                mptr = (mon_g + 1) % NR;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rsp_valid", 128'(bus.rsp_valid), 128'(1) << sb[0].owner);
                check("rsp_data", bus.rsp_data, sb[0].data);
                void'(sb.pop_front());
            end else begin
                check("rsp_idle", 128'(bus.rsp_valid), 128'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        check({tag, "_sb_empty"}, 128'(sb.size()), 128'h0);
        check({tag, "_idle"}, 128'(busy), 128'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_ready"}, 128'(bus.key_ready), 128'h0);
        check({tag, "_req_ready"}, 128'(bus.req_ready), 128'h0);
        check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'h0);
        check({tag, "_rsp_data"}, bus.rsp_data, 128'h0);
        check({tag, "_set_key"}, 128'(eng_set_key), 128'h0);
        check({tag, "_eng_key"}, eng_key, 128'h0);
        check({tag, "_start"}, 128'(eng_start), 128'h0);
        check({tag, "_state"}, eng_state, 128'h0);
        check({tag, "_halt"}, 128'(eng_halt), 128'h0);
        check({tag, "_busy"}, 128'(busy), 128'h0);
        check({tag, "_err"}, 128'(err), 128'h0);
    endtask

    int t_grant, t_key;

    initial begin
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;

        // T1 key load; req0 already waiting must not be granted before RUN
        tick();
        bus.key_valid = 1'b1;
        bus.key_in    = K1;
        mkey          = K1;
        bus.req_valid = 4'b0001;
        bus.req_data[127:0] = PT0;
        @(negedge clk);
        check("t1_nokey_key_ready", 128'(bus.key_ready), 128'h0);
        tick();
        @(negedge clk);
        check("t1_key_ready", 128'(bus.key_ready), 128'h1);
        check("t1_set_key", 128'(eng_set_key), 128'h1);
        check("t1_eng_key", eng_key, K1);
        check("t1_busy_keyload", 128'(busy), 128'h1);

        // T2 FIPS-197 vector through requester 0
        tick();
        bus.key_valid = 1'b0;
        model_run     = 1'b1;
        @(negedge clk);
        t_grant = cyc;
        check("t1_key_ready_off", 128'(bus.key_ready), 128'h0);
        check("t1_set_key_off", 128'(eng_set_key), 128'h0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("t2_eng_start", 128'(eng_start), 128'h1);
        check("t2_eng_state", eng_state, PT0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) break;
        end
        check("t2_latency", 128'(cyc - t_grant), 128'(LAT + 2));
        check("t2_rsp_valid", 128'(bus.rsp_valid), 128'h1);
        check("t2_rsp_data", bus.rsp_data, CT0);

        // T3 fairness with all requesters active
        for (int i = 0; i < 30; i++) begin
            tick();
            bus.req_valid = '1;
            for (int r = 0; r < NR; r++) bus.req_data[128*r +: 128] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (i == 20 || i == 25) begin
                check("t3_in_flight", 128'(dut.in_flight), 128'(LAT));
                check("t3_start_and_retire", 128'({eng_start, eng_out_valid}), 128'h3);
                check("t3_busy", 128'(busy), 128'h1);
            end
        end

        // T4 single requester 2 back-to-back
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.req_valid = 4'b0100;
            bus.req_data[256 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("t4_ptr", 128'(dut.ptr), 128'h3);
        wait_drain("t4");

        // T5 rekey with 5 blocks in flight
        tick();
        bus.req_valid = '1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick();
        end
        bus.key_valid = 1'b1;
        bus.key_in    = K2;
        @(negedge clk);
        t_key = cyc;
        tick();
        model_run = 1'b0;
        @(negedge clk);
        check("t5_last_grant_issued", 128'(eng_start), 128'h1);
        check("t5_outstanding", 128'(sb.size()), 128'h5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (eng_halt) break;
        end
        check("t5_halt", 128'(eng_halt), 128'h1);
        check("t5_halt_cycle", 128'(cyc - t_key), 128'(LAT + 3));
        check("t5_all_rsp_before_halt", 128'(sb.size()), 128'h0);
        check("t5_no_set_key_in_halt", 128'(eng_set_key), 128'h0);
        tick();
        mkey = K2;
        @(negedge clk);
        check("t5_halt_one_cycle", 128'(eng_halt), 128'h0);
        check("t5_set_key", 128'(eng_set_key), 128'h1);
        check("t5_key_ready", 128'(bus.key_ready), 128'h1);
        check("t5_eng_key", eng_key, K2);
        tick();
        bus.key_valid = 1'b0;
        model_run     = 1'b1;
        @(negedge clk);
        check("t5_grants_resume", 128'(bus.req_ready != '0), 128'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int r = 0; r < NR; r++) bus.req_data[128*r +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
        bus.req_valid = '0;
        wait_drain("t5");

        // T6a spurious engine result with an empty pipe
        check("t6_err_clear", 128'(err), 128'h0);
        tick();
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        @(negedge clk);
        check("t6_err_set", 128'(err), 128'h1);
        check("t6_no_rsp", 128'(bus.rsp_valid), 128'h0);
        repeat (3) @(negedge clk);
        check("t6_err_sticky", 128'(err), 128'h1);

        // T6b reset mid-stream discards in-flight blocks
        tick();
        bus.req_valid = '1;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        sb.delete();
        model_run = 1'b0;
        mptr      = 0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_post_rst_busy", 128'(busy), 128'h0);
        check("t6_post_rst_err", 128'(err), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
